// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, decoder state type and event layout
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EV_W   = 10;
    localparam int EV_EXT = 9;
    localparam int EV_BRK = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word fall-through FIFO; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == FULL_CNT;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: decodes E0/F0 prefixed scan codes into make/break events,
// filters typematic repeats, tracks the held key and buffers events in a FIFO.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [EV_W-1:0]  ev_data,
    output logic             held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    input  logic             clr_ovf
);
    state_e           state_q, state_d;
    logic             held_q, held_d;
    logic [7:0]       code_q, code_d;
    logic             hext_q, hext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic            is_e0, is_f0, fire, ev_ext, ev_brk, match, push, new_make;
    logic            fifo_full, fifo_empty;
    logic [EV_W-1:0] ev_in;

    assign is_e0  = rx_data == PS2_EXT;
    assign is_f0  = rx_data == PS2_BRK;
    assign fire   = rx_valid && !is_e0 && !is_f0;
    assign ev_ext = state_q == EXT || state_q == EXT_BRK;
    assign ev_brk = state_q == BRK || state_q == EXT_BRK;

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                IDLE:    state_d = is_e0 ? EXT : is_f0 ? BRK : IDLE;
                EXT:     state_d = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
                BRK:     state_d = is_f0 ? BRK : is_e0 ? EXT_BRK : IDLE;
                EXT_BRK: state_d = (is_e0 || is_f0) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A make that matches the held key is a typematic repeat and is swallowed.
    always_comb begin
        match    = held_q && code_q == rx_data && hext_q == ev_ext;
        push     = fire && (ev_brk || !match);
        new_make = fire && !ev_brk && !match;
        ev_in           = '0;
        ev_in[EV_EXT]   = ev_ext;
        ev_in[EV_BRK]   = ev_brk;
        ev_in[7:0]      = rx_data;
        held_d = new_make ? 1'b1 : (fire && ev_brk && match) ? 1'b0 : held_q;
        code_d = new_make ? rx_data : code_q;
        hext_d = new_make ? ev_ext : hext_q;
        cnt_d  = cnt_q + CNT_W'(new_make);
        ovf_d  = (push && fifo_full && !(ev_valid && ev_ready)) ? 1'b1 :
                 clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            code_q  <= '0;
            hext_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            code_q  <= code_d;
            hext_q  <= hext_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EV_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  (ev_in),
        .full (fifo_full),
        .pop  (ev_ready),
        .empty(fifo_empty),
        .dout (ev_data)
    );

    assign ev_valid  = !fifo_empty;
    assign held      = held_q;
    assign held_code = code_q;
    assign held_ext  = hext_q;
    assign press_cnt = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: scoreboard bench; expected events are queued as bytes are
// sent and compared whenever the DUT hands an event to the consumer.
module tb_ps2_key_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [9:0] ev_data;
    logic       held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_cnt;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] exp_q [$];
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .held     (held),
        .held_code(held_code),
        .held_ext (held_ext),
        .press_cnt(press_cnt),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1; leaves the bench at the next posedge+#1.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ev_valid"}, ev_valid, 0);
        check({tag, "_ev_data"}, ev_data, 0);
        check({tag, "_held"}, held, 0);
        check({tag, "_held_code"}, held_code, 0);
        check({tag, "_held_ext"}, held_ext, 0);
        check({tag, "_press_cnt"}, press_cnt, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) check("extra_event", ev_valid, 0);
            else check("ev_data", ev_data, exp_q.pop_front());
        end
    end

    initial begin
        #3;
        check_reset_vals("rst0");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        ev_ready = 1'b1;

        send(8'h1C); exp_q.push_back(10'h01C); exp_cnt++;
        check("mk_valid", ev_valid, 1);
        check("mk_cnt", press_cnt, exp_cnt);
        check("mk_held", held, 1);
        check("mk_code", held_code, 8'h1C);
        send(8'hF0);
        check("pfx_held", held, 1);
        send(8'h1C); exp_q.push_back(10'h11C);
        check("brk_held", held, 0);
        check("brk_code", held_code, 8'h1C);
        drain();

        send(8'hE0);
        send(8'h75); exp_q.push_back(10'h275); exp_cnt++;
        check("ext_held_ext", held_ext, 1);
        check("ext_code", held_code, 8'h75);
        send(8'hE0); send(8'hF0);
        send(8'h75); exp_q.push_back(10'h375);
        check("ext_brk_held", held, 0);
        check("ext_cnt", press_cnt, exp_cnt);
        drain();

        send(8'h1C); exp_q.push_back(10'h01C); exp_cnt++;
        send(8'h1C);
        send(8'h1C);
        check("typ_cnt", press_cnt, exp_cnt);
        send(8'hF0);
        send(8'h1C); exp_q.push_back(10'h11C);
        drain();

        ev_ready = 1'b0;
        send(8'h15); exp_q.push_back(10'h015); exp_cnt++;
        send(8'h1D); exp_q.push_back(10'h01D); exp_cnt++;
        send(8'h24); exp_q.push_back(10'h024); exp_cnt++;
        send(8'h2D); exp_q.push_back(10'h02D); exp_cnt++;
        check("full_no_ovf", overflow, 0);
        send(8'h2C); exp_cnt++;
        check("ovf_set", overflow, 1);
        check("ovf_cnt", press_cnt, exp_cnt);
        check("ovf_head", ev_data, 10'h015);
        check("ovf_held_code", held_code, 8'h2C);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);

        ev_ready = 1'b1;
        send(8'h33); exp_q.push_back(10'h033); exp_cnt++;
        check("fullpp_ovf", overflow, 0);
        check("fullpp_cnt", press_cnt, exp_cnt);
        drain();
        check("empty_valid", ev_valid, 0);

        send(8'hF0);
        reset = 1'b1;
        #1;
        check_reset_vals("rst1");
        @(posedge clk); #1;
        check_reset_vals("rst2");
        reset = 1'b0;
        exp_cnt = 8'd0;
        send(8'h1C); exp_q.push_back(10'h01C); exp_cnt++;
        check("post_rst_cnt", press_cnt, exp_cnt);
        check("post_rst_held", held, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Key-event controller between the PS/2 frame receiver and the keyboard consumers (display, counters, CPU-side reader). It sequences raw scan-code bytes through a prefix state machine (E0 extended, F0 break), suppresses typematic repeats, tracks the currently held key and counts distinct presses. Decoded make/break events are buffered in a small FIFO behind a valid/ready handshake, so a slow consumer never stalls the receiver.

## Interface
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, ≥2.
- `CNT_W`, 8, width of `press_cnt`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx_valid` in 1: one-cycle pulse; a checked byte is on `rx_data`.
- `rx_data` in 8: scan-code byte from the frame receiver.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head this cycle.
- `ev_data` out 10: `{ext, brk, code[7:0]}` of the FIFO head (first-word fall-through).
- `held` out 1: a key is currently pressed.
- `held_code` out 8: code of the held key.
- `held_ext` out 1: the held key is extended.
- `press_cnt` out CNT_W: number of accepted make events, wraps.
- `overflow` out 1: sticky; an event was dropped on a full FIFO.
- `clr_ovf` in 1: clears `overflow`.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK. State advances only on cycles where `rx_valid`=1.
- IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte emits a make event with ext=0 and stays in IDLE.
- EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte emits a make event with ext=1 and goes to IDLE.
- BRK: F0 stays in BRK. E0 goes to EXT_BRK. Any other byte emits a break event with ext=0 and goes to IDLE.
- EXT_BRK: E0 or F0 stays in EXT_BRK. Any other byte emits a break event with ext=1 and goes to IDLE.
- Make event whose code and ext match a held key (`held`=1, same `held_code`, same `held_ext`):
  - it is a typematic repeat;
  - no FIFO push, no count change.
- Any other make event:
  - push it to the FIFO;
  - `press_cnt` increments modulo 2^CNT_W;
  - `held`←1, and `held_code`/`held_ext` take the new key.
- Break event:
  - always pushed to the FIFO;
  - if it matches the held key, `held`←0 and `held_code`/`held_ext` keep their last values;
  - otherwise held state is unchanged.
- The counter increments even if the FIFO push is dropped.
- FIFO full with a push and no pop in the same cycle: the event is dropped, `overflow`←1, FIFO contents unchanged.
- FIFO full with push and pop (`ev_valid`&`ev_ready`) in the same cycle: the push is accepted and occupancy is unchanged.
- FIFO empty: `ev_ready` is ignored and `ev_data` is don't-care.
- If `overflow` is being set and `clr_ovf`=1 in the same cycle, set wins.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty;
  - `ev_valid`=0, `ev_data`=0;
  - `held`=0, `held_code`=0, `held_ext`=0;
  - `press_cnt`=0, `overflow`=0.
- Latency: a final byte at cycle N (`rx_valid`=1) with the FIFO empty gives `ev_valid`=1 at N+1, and `press_cnt`/`held` update at N+1.
- Prefix bytes produce no outputs, only a state change visible at N+1.
- A pop at cycle N makes the next entry visible at N+1. `ev_valid` falls at N+1 when the last entry is popped.
- Full throughput: one event per cycle in and one out.
- Reset asserted mid-sequence (e.g. after F0) discards the pending prefix. The next byte is decoded from IDLE.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the FSM state enum;
  - the event field widths and bit positions (EV_W=10, EV_EXT=9, EV_BRK=8).
- Sub-module `ps2_event_fifo`: synchronous FWFT FIFO with parameters DEPTH and WIDTH and ports push/full/pop/empty. It is instantiated once.
- The FSM, held-key tracking and counter live in `ps2_key_ctrl`.

## Test plan
- Byte 1C with `ev_ready`=1 → one event `{0,0,1C}` at N+1, `press_cnt`=1, `held`=1, `held_code`=1C. Then F0 1C → event `{0,1,1C}`, `held`=0.
- E0 75, then E0 F0 75 → events `{1,0,75}` and `{1,1,75}`, `press_cnt`=1.
- 1C 1C 1C (typematic), then F0 1C → exactly two events, make then break, and `press_cnt`=1.
- `ev_ready`=0 and 5 make events with distinct codes 15,1D,24,2D,2C → first 4 buffered in order, 2C dropped, `overflow`=1, `press_cnt`=5. `clr_ovf` pulse → `overflow`=0.
- FIFO full while `ev_ready`=1 and a new make arrives in the same cycle → push accepted, no overflow, order preserved.
- Send F0, assert `reset` for 1 cycle, then send 1C → make event `{0,0,1C}` (not a break), and all outputs were at their reset values during reset.
